// File: rtl/data_ram_resp_pkg.sv
// -----------------------------------------------------------------------------
// data_ram_resp_pkg
// Shared core bus definitions: access-size encodings used by the core and the
// data RAM responder, the responder FSM state type, and the read-lane steering
// helper.
// -----------------------------------------------------------------------------
package data_ram_resp_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Right-justify the addressed lane(s) of a memory word and zero the rest.
    function automatic logic [31:0] rd_steer(input logic [31:0] q,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size);
        logic [31:0] sh;
        sh = q >> {lane, 3'b000};
        case (size)
            SIZE_BYTE: rd_steer = {24'h0, sh[7:0]};
            SIZE_HALF: rd_steer = {16'h0, sh[15:0]};
            default:   rd_steer = sh;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_resp_if.sv
// -----------------------------------------------------------------------------
// data_ram_resp_if
// Core-to-data-RAM request/response bus.
//   master : core side   (drives requests, receives read data / status)
//   slave  : responder   (receives requests, drives read data / status)
// Signals:
//   ahb_rd_en, ahb_wr_en : request strobes
//   ahb_addr, ahb_size   : byte address and access size
//   ahb_wr_data          : write data, right-justified
//   ahb_rd_data          : read data, right-justified, zero-extended
//   ahb_rd_vld           : one-cycle read completion strobe
//   ahb_busy             : responder cannot accept a request
//   bus_err              : one-cycle error strobe at completion
// -----------------------------------------------------------------------------
interface data_ram_resp_if;
    logic        ahb_rd_en;
    logic        ahb_wr_en;
    logic [31:0] ahb_addr;
    logic [1:0]  ahb_size;
    logic [31:0] ahb_wr_data;
    logic [31:0] ahb_rd_data;
    logic        ahb_rd_vld;
    logic        ahb_busy;
    logic        bus_err;

    modport master (
        output ahb_rd_en, ahb_wr_en, ahb_addr, ahb_size, ahb_wr_data,
        input  ahb_rd_data, ahb_rd_vld, ahb_busy, bus_err
    );

    modport slave (
        input  ahb_rd_en, ahb_wr_en, ahb_addr, ahb_size, ahb_wr_data,
        output ahb_rd_data, ahb_rd_vld, ahb_busy, bus_err
    );
endinterface

// File: rtl/data_ram_resp_ram_bytelane.sv
// -----------------------------------------------------------------------------
// ram_bytelane
// Single-port 2^AW x 32 array with four byte write enables and a registered
// read port. Read data only updates on a read cycle, so it holds across writes.
// Ports:
//   clk     : clock
//   i_rd_en : read this cycle (o_rdata updates at the edge)
//   i_we    : byte-lane write enables
//   i_addr  : word address
//   i_wdata : write data (already lane-steered)
//   o_rdata : registered read data
// -----------------------------------------------------------------------------
module ram_bytelane #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          i_rd_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_rd_en) begin
            o_rdata <= r_mem[i_addr];
        end
    end
endmodule

// File: rtl/data_ram_resp.sv
// -----------------------------------------------------------------------------
// data_ram_resp
// Data RAM responder: accepts one read or write per WAIT_CYC+1 cycles, inserts
// WAIT_CYC wait states, decodes range/alignment errors and steers byte lanes
// into a ram_bytelane array.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : core request/response bus (slave side)
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready; request decoded from the bus, completes at once if W=0
// ST_WAIT | access latched; counting wait states, busy asserted
// -----------------------------------------------------------------------------
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int          RAM_AW    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          WAIT_CYC  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    data_ram_resp_if.slave bus
);
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYC);
    localparam int         LP_HI   = RAM_AW + 2;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_rd_vld;
    logic        r_err;
    logic        r_rd;
    logic        r_wr;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [31:0] r_wdata;
    logic        r_rd_ok;
    logic [1:0]  r_rd_lane;
    logic [1:0]  r_rd_size;

    logic        w_accept;
    logic        w_done;
    logic        w_cur_rd;
    logic        w_cur_wr;
    logic [31:0] w_cur_addr;
    logic [1:0]  w_cur_size;
    logic [31:0] w_cur_wdata;
    logic        w_in_range;
    logic        w_misalign;
    logic        w_addr_ok;
    logic        w_err;
    logic        w_rd_only;
    logic        w_ram_rd;
    logic [3:0]  w_ram_we;
    logic [31:0] w_ram_wdata;
    logic [31:0] w_ram_q;

    assign w_accept = (bus.ahb_rd_en | bus.ahb_wr_en) & ~r_busy;

    // In IDLE the access comes straight off the bus so a zero-wait access
    // completes at its accept edge; in WAIT the latched copy is used.
    assign w_cur_rd    = (r_state == ST_IDLE) ? bus.ahb_rd_en   : r_rd;
    assign w_cur_wr    = (r_state == ST_IDLE) ? bus.ahb_wr_en   : r_wr;
    assign w_cur_addr  = (r_state == ST_IDLE) ? bus.ahb_addr    : r_addr;
    assign w_cur_size  = (r_state == ST_IDLE) ? bus.ahb_size    : r_size;
    assign w_cur_wdata = (r_state == ST_IDLE) ? bus.ahb_wr_data : r_wdata;

    assign w_done = (r_state == ST_IDLE) ? (w_accept && (LP_WAIT == 4'd0))
                                         : (r_cnt == LP_WAIT);

    // BASE_ADDR is aligned to the array size, so a range check is a tag compare.
    assign w_in_range = (w_cur_addr[31:LP_HI] == BASE_ADDR[31:LP_HI]);
    assign w_misalign = ((w_cur_size == SIZE_HALF) && w_cur_addr[0]) ||
                        ((w_cur_size == SIZE_WORD) && (w_cur_addr[1:0] != 2'b00));
    assign w_addr_ok  = w_in_range && !w_misalign && (w_cur_size != 2'b11);
    assign w_err      = !w_addr_ok || (w_cur_rd && w_cur_wr);
    assign w_rd_only  = w_cur_rd && !w_cur_wr;
    assign w_ram_rd   = w_done && w_rd_only && w_addr_ok;

    always_comb begin
        w_ram_we    = 4'b0000;
        w_ram_wdata = w_cur_wdata;
        case (w_cur_size)
            SIZE_BYTE: begin
                w_ram_wdata = {4{w_cur_wdata[7:0]}};
                w_ram_we    = 4'b0001 << w_cur_addr[1:0];
            end
            SIZE_HALF: begin
                w_ram_wdata = {2{w_cur_wdata[15:0]}};
                w_ram_we    = w_cur_addr[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_WORD: w_ram_we = 4'b1111;
            default:   w_ram_we = 4'b0000;
        endcase
        // Commits only at completion and only for legal addresses; a write
        // with rd_en also high still commits.
        if (!(w_done && w_cur_wr && w_addr_ok)) begin
            w_ram_we = 4'b0000;
        end
    end

    ram_bytelane #(.AW(RAM_AW)) u_ram (
        .clk     (clk),
        .i_rd_en (w_ram_rd),
        .i_we    (w_ram_we),
        .i_addr  (w_cur_addr[LP_HI-1:2]),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_err     <= 1'b0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= 32'h0;
            r_size    <= 2'b00;
            r_wdata   <= 32'h0;
            r_rd_ok   <= 1'b0;
            r_rd_lane <= 2'b00;
            r_rd_size <= 2'b00;
        end else begin
            r_rd_vld <= w_done && w_rd_only;
            r_err    <= w_done && w_err;
            if (w_done && w_rd_only) begin
                r_rd_ok   <= w_addr_ok;
                r_rd_lane <= w_cur_addr[1:0];
                r_rd_size <= w_cur_size;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rd    <= bus.ahb_rd_en;
                        r_wr    <= bus.ahb_wr_en;
                        r_addr  <= bus.ahb_addr;
                        r_size  <= bus.ahb_size;
                        r_wdata <= bus.ahb_wr_data;
                        if (LP_WAIT != 4'd0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= 4'd1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == LP_WAIT) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ahb_busy    = r_busy;
    assign bus.ahb_rd_vld  = r_rd_vld;
    assign bus.bus_err     = r_err;
    assign bus.ahb_rd_data = r_rd_ok ? rd_steer(w_ram_q, r_rd_lane, r_rd_size) : 32'h0;
endmodule

// File: doc/data_ram_resp.md
DATA_RAM_RESP -- requirements
Module: data_ram_resp

Interface
REQ-001 SHALL have parameter RAM_AW, default 8, word-address width (array of 2^RAM_AW 32-bit words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base address of the array; low (RAM_AW+2) bits SHALL be zero.
REQ-003 SHALL have parameter WAIT_CYC, default 0, range 0..15, wait states inserted per access.
REQ-004 SHALL have port clk, input, 1, single clock for the block; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ahb_rd_en, input, 1, core read request.
REQ-007 SHALL have port ahb_wr_en, input, 1, core write request.
REQ-008 SHALL have port ahb_addr, input, 32, byte address.
REQ-009 SHALL have port ahb_size, input, 2, access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 SHALL have port ahb_wr_data, input, 32, write data, right-justified.
REQ-011 SHALL have port ahb_rd_data, output, 32, read data, right-justified, zero-extended.
REQ-012 SHALL have port ahb_rd_vld, output, 1, one-cycle read-completion strobe.
REQ-013 SHALL have port ahb_busy, output, 1, responder cannot accept a request.
REQ-014 SHALL have port bus_err, output, 1, one-cycle error strobe at completion.

Function
REQ-015 Request SHALL be accepted at a rising edge E where (ahb_rd_en | ahb_wr_en) & !ahb_busy; requests while ahb_busy=1 SHALL be ignored (initiator holds them).
REQ-016 On accept, address, size, write data and operation SHALL be latched; inputs after E SHALL NOT affect the access.
REQ-017 FSM states: IDLE, WAIT. IDLE -> WAIT on accept when WAIT_CYC>0; WAIT -> IDLE when wait counter reaches WAIT_CYC; WAIT_CYC=0 SHALL never enter WAIT.
REQ-018 ahb_busy SHALL be registered, high exactly the WAIT_CYC cycles after E, low otherwise.
REQ-019 Array access (read or write commit) SHALL occur at completion edge C = E+WAIT_CYC.
REQ-020 ahb_rd_vld SHALL be high for exactly the one cycle following C for accepted reads; ahb_rd_data SHALL be valid in that cycle and hold until the next read completion.
REQ-021 Throughput SHALL be one access per WAIT_CYC+1 cycles; with WAIT_CYC=0, back-to-back accesses every cycle.
REQ-022 Byte write SHALL write ahb_wr_data[7:0] into lane addr[1:0]; halfword writes [15:0] into lanes addr[1]*2+{0,1}; word writes all lanes; other lanes unchanged.
REQ-023 Byte/halfword reads SHALL return the addressed lane(s) in bits [7:0]/[15:0], upper bits zero.
REQ-024 Error conditions: address outside BASE_ADDR..BASE_ADDR+4*2^RAM_AW-1; halfword with addr[0]=1; word with addr[1:0]!=0; ahb_size=11; rd_en and wr_en both high.
REQ-025 On error, bus_err SHALL pulse in the cycle following C; erroneous writes SHALL be dropped; erroneous reads SHALL return 0 with ahb_rd_vld pulsed.
REQ-026 Simultaneous rd_en and wr_en SHALL be treated as a write (performed if otherwise legal) plus bus_err pulse; no ahb_rd_vld.
REQ-027 Read of a word written at the immediately preceding completion edge SHALL return the new data.

Reset
REQ-028 rst_n low SHALL asynchronously force: FSM IDLE, wait counter 0, ahb_busy 0, ahb_rd_vld 0, bus_err 0, ahb_rd_data 32'h0.
REQ-029 Reset mid-access SHALL abandon it: pending write dropped, no rd_vld; array contents SHALL NOT be reset.
REQ-030 First request SHALL be accepted at the first rising edge after rst_n deasserts.

Structure
REQ-031 Size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) SHALL live in the shared core bus package, used by core and responder.
REQ-032 Array SHALL be a sub-module ram_bytelane: single-port, 2^RAM_AW x 32, 4 byte write enables, registered read.
REQ-033 FSM, wait counter, decode/alignment check and lane steering SHALL live in data_ram_resp.

Verification
REQ-034 W=0: word write 0xDEADBEEF @0x10, next cycle read @0x10 -> rd_vld one cycle later, rd_data 0xDEADBEEF, busy never high.
REQ-035 W=3: read @0x04 accepted at E -> busy high 3 cycles, rd_vld high only in cycle E+4; rd_en held during busy causes no second access.
REQ-036 Byte write 0xAA @0x13 over 0x11223344 -> word read 0xAA223344; byte read @0x13 -> 0x000000AA; halfword read @0x12 -> 0x0000AA22.
REQ-037 Halfword read @0x11, size 11 @0x10, word write @0x400 (RAM_AW=8) -> bus_err pulse each, reads return 0, memory unchanged.
REQ-038 rd_en and wr_en both high, word 0x5A5A5A5A @0x20 -> write performed, bus_err pulse, no rd_vld.
REQ-039 W=3: rst_n low during busy of write 0x12345678 @0x30 -> outputs zero immediately, later read @0x30 returns prior contents.
